// File: rtl/sdram_bridge_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_bridge_pkg                                                      |
// | Shared state encoding, timeout read pattern and strobe/mask helper    |
// | for the CPU-to-SDRAM-controller bridge.                               |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package sdram_bridge_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = IDLE,
    ST_ISSUE    = ISSUE,
    ST_WAIT_ACK = WAIT_ACK,
    ST_DONE     = DONE
  } state_t;

  // Returned to the CPU when the controller never acknowledges.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // CPU strobes are active-high enables; controller masks are active-high
  // "do not write this byte", so an all-zero strobe (read) masks everything.
  function automatic logic [3:0] strb_to_mask(input logic [3:0] strb);
    return ~strb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_bridge_rd_cache.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_bridge_rd_cache                                                 |
// | One-entry read cache: tag compare, fill on read completion, byte      |
// | merge on write-through to the cached word, invalidate on timeout.     |
// | Only instantiated when SDRAM_BRIDGE_RD_CACHE_EN is defined.           |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module sdram_bridge_rd_cache #(
  parameter int SOC_ADDR_WIDTH = 23
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [SOC_ADDR_WIDTH-1:0] lookup_addr,
  output logic                      hit,
  output logic [31:0]               hit_data,
  input  logic [SOC_ADDR_WIDTH-1:0] upd_addr,
  input  logic                      fill_en,
  input  logic [31:0]               fill_data,
  input  logic                      wr_en,
  input  logic [31:0]               wr_data,
  input  logic [3:0]                wr_strb,
  input  logic                      inval
);

  logic                      valid;
  logic [SOC_ADDR_WIDTH-1:0] tag;
  logic [31:0]               data;

  assign hit      = valid && (tag == lookup_addr);
  assign hit_data = data;

  // Entry update: invalidate wins, then fill, then write-through merge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (fill_en) begin
      valid <= 1'b1;
      tag   <= upd_addr;
      data  <= fill_data;
    end else if (wr_en && valid && (tag == upd_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) data[8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_soc_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sdram_soc_bridge                                                      |
// | CPU valid/ready memory bus to SDRAM controller single-pulse command   |
// | bridge with one transaction in flight and a completion watchdog.      |
// | Optional read cache: define SDRAM_BRIDGE_RD_CACHE_EN.                 |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module sdram_soc_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int SOC_ADDR_WIDTH = 23,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                      clk,
  input  logic                      reset_n_port,
  input  logic                      mem_valid_port,
  output logic                      mem_ready_port,
  input  logic [31:0]               mem_addr_port,
  input  logic [31:0]               mem_wdata_port,
  input  logic [3:0]                mem_wstrb_port,
  output logic [31:0]               mem_rdata_port,
  output logic                      timeout_err_port,
  input  logic                      ctrl_busy_port,
  input  logic                      ctrl_ready_port,
  output logic [SOC_ADDR_WIDTH-1:0] ctrl_addr_port,
  output logic [31:0]               ctrl_wr_data_port,
  output logic [3:0]                ctrl_wr_mask_port,
  output logic                      ctrl_wr_en_port,
  output logic                      ctrl_rd_en_port,
  input  logic [31:0]               ctrl_rd_data_port
);

  localparam int                WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  state_t                    state, state_n;
  logic [WDOG_W-1:0]         wdog, wdog_n;
  logic                      mem_ready_n, timeout_err_n, wr_en_n, rd_en_n;
  logic [31:0]               mem_rdata_n, wr_data_n;
  logic [3:0]                wr_mask_n;
  logic [SOC_ADDR_WIDTH-1:0] addr_n, word_addr;
  logic                      is_write;
  logic                      cache_hit, cache_fill, cache_wupd, cache_inval;
  logic [31:0]               cache_data;
  logic                      unused_addr;

  assign word_addr   = mem_addr_port[SOC_ADDR_WIDTH+1:2];
  assign unused_addr = &{1'b0, mem_addr_port[1:0], mem_addr_port[31:SOC_ADDR_WIDTH+2]};
  // The latched mask doubles as the read/write flag: reads latch 4'hF.
  assign is_write    = (ctrl_wr_mask_port != 4'hF);

`ifdef SDRAM_BRIDGE_RD_CACHE_EN
  sdram_bridge_rd_cache #(
    .SOC_ADDR_WIDTH(SOC_ADDR_WIDTH)
  ) u_rd_cache (
    .clk        (clk),
    .reset_n    (reset_n_port),
    .lookup_addr(word_addr),
    .hit        (cache_hit),
    .hit_data   (cache_data),
    .upd_addr   (ctrl_addr_port),
    .fill_en    (cache_fill),
    .fill_data  (ctrl_rd_data_port),
    .wr_en      (cache_wupd),
    .wr_data    (ctrl_wr_data_port),
    .wr_strb    (~ctrl_wr_mask_port),
    .inval      (cache_inval)
  );
`else
  logic unused_cache;
  assign cache_hit    = 1'b0;
  assign cache_data   = '0;
  assign unused_cache = &{1'b0, cache_fill, cache_wupd, cache_inval};
`endif

  // State and registered outputs; every output resets asynchronously.
  always_ff @(posedge clk or negedge reset_n_port) begin
    if (!reset_n_port) begin
      state             <= ST_IDLE;
      wdog              <= '0;
      mem_ready_port    <= 1'b0;
      mem_rdata_port    <= '0;
      timeout_err_port  <= 1'b0;
      ctrl_addr_port    <= '0;
      ctrl_wr_data_port <= '0;
      ctrl_wr_mask_port <= 4'hF;
      ctrl_wr_en_port   <= 1'b0;
      ctrl_rd_en_port   <= 1'b0;
    end else begin
      state             <= state_n;
      wdog              <= wdog_n;
      mem_ready_port    <= mem_ready_n;
      mem_rdata_port    <= mem_rdata_n;
      timeout_err_port  <= timeout_err_n;
      ctrl_addr_port    <= addr_n;
      ctrl_wr_data_port <= wr_data_n;
      ctrl_wr_mask_port <= wr_mask_n;
      ctrl_wr_en_port   <= wr_en_n;
      ctrl_rd_en_port   <= rd_en_n;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_n       = state;
    wdog_n        = wdog;
    mem_ready_n   = 1'b0;
    mem_rdata_n   = mem_rdata_port;
    timeout_err_n = timeout_err_port;
    addr_n        = ctrl_addr_port;
    wr_data_n     = ctrl_wr_data_port;
    wr_mask_n     = ctrl_wr_mask_port;
    wr_en_n       = 1'b0;
    rd_en_n       = 1'b0;
    cache_fill    = 1'b0;
    cache_wupd    = 1'b0;
    cache_inval   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_valid_port && (mem_wstrb_port == 4'h0) && cache_hit) begin
          // Cache hit bypasses the controller even while it is busy.
          mem_rdata_n = cache_data;
          state_n     = ST_DONE;
        end else if (mem_valid_port && !ctrl_busy_port) begin
          addr_n    = word_addr;
          wr_data_n = mem_wdata_port;
          wr_mask_n = strb_to_mask(mem_wstrb_port);
          wr_en_n   = |mem_wstrb_port;
          rd_en_n   = ~|mem_wstrb_port;
          state_n   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_n  = '0;
        state_n = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ctrl_ready_port) begin
          if (is_write) begin
            cache_wupd = 1'b1;
          end else begin
            mem_rdata_n = ctrl_rd_data_port;
            cache_fill  = 1'b1;
          end
          mem_ready_n = 1'b1;
          state_n     = ST_DONE;
        end else if (wdog == WDOG_LAST) begin
          mem_rdata_n   = TIMEOUT_RDATA;
          timeout_err_n = 1'b1;
          cache_inval   = 1'b1;
          mem_ready_n   = 1'b1;
          state_n       = ST_DONE;
        end else begin
          wdog_n = wdog + 1'b1;
        end
      end
      ST_DONE: begin
        // Arrivals from WAIT_ACK already carry the pulse; a cache hit
        // arrives without it and raises it here before returning.
        if (mem_ready_port) state_n = ST_IDLE;
        else                mem_ready_n = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/sdram_soc_bridge.md
Name: sdram_soc_bridge

Overview:
- Upstream of sdram_controller.
- Converts a CPU native memory bus (valid/ready, byte address, write strobes) into the controller's SoC-side single-pulse wr_en/rd_en, busy/ready interface.
- Holds one transaction in flight, translates byte strobes to DQM-style masks, and guards against a stuck controller with a completion watchdog.

Parameters:
- SOC_ADDR_WIDTH, 23, controller word-address width (8M x 32-bit).
- TIMEOUT_CYCLES, 4095, max cycles from command issue to ctrl_ready_port before forced completion.

Ports:
- clk  in  1  system clock (85 MHz nominal)
- reset_n_port  in  1  asynchronous active-low reset
- mem_valid_port  in  1  CPU request valid; held until mem_ready_port
- mem_ready_port  out  1  one-cycle completion pulse to CPU
- mem_addr_port  in  32  byte address; bits [1:0] ignored
- mem_wdata_port  in  32  write data
- mem_wstrb_port  in  4  byte strobes; 4'b0000 = read
- mem_rdata_port  out  32  read data, valid with mem_ready_port
- timeout_err_port  out  1  sticky watchdog flag
- ctrl_busy_port  in  1  from controller soc_side_busy
- ctrl_ready_port  in  1  from controller soc_side_ready
- ctrl_addr_port  out  SOC_ADDR_WIDTH  word address = mem_addr_port[SOC_ADDR_WIDTH+1:2]
- ctrl_wr_data_port  out  32  latched write data
- ctrl_wr_mask_port  out  4  ~mem_wstrb_port (1 = byte masked)
- ctrl_wr_en_port  out  1  single-cycle write command
- ctrl_rd_en_port  out  1  single-cycle read command
- ctrl_rd_data_port  in  32  controller read data, valid with ctrl_ready_port

Behaviour:
- Reset (async, all outputs): mem_ready=0, mem_rdata=0, ctrl_wr_en=0, ctrl_rd_en=0, ctrl_addr=0, ctrl_wr_data=0, ctrl_wr_mask=4'hF, timeout_err=0, state=IDLE.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_ACK, DONE.
- IDLE:
  - On mem_valid && !ctrl_busy: latch addr, wdata and ~wstrb, then go to ISSUE.
  - If ctrl_busy is high (init, refresh), hold in IDLE with no timeout counting.
- ISSUE:
  - Exactly one of ctrl_wr_en or ctrl_rd_en is high for exactly 1 cycle: write if latched wstrb != 0, else read.
  - Load the watchdog counter with 0, then go to WAIT_ACK.
- WAIT_ACK:
  - On ctrl_ready: if read, capture ctrl_rd_data into mem_rdata (a write leaves mem_rdata unchanged). Go to DONE.
  - Otherwise increment the counter. When counter == TIMEOUT_CYCLES-1: set mem_rdata=32'hDEAD_BEEF, set timeout_err=1 (sticky until reset), go to DONE.
- DONE: mem_ready=1 for one cycle, then go to IDLE.
- Latency: request accepted at cycle 0 → command at cycle 1 → ctrl_ready at cycle N → mem_ready at cycle N+1. Minimum is 3 cycles for a 1-cycle controller.
- ctrl_ready outside WAIT_ACK: ignored.
- Changes on mem_* inputs between accept and mem_ready: ignored; latched values are used.
- mem_valid low in IDLE: no command is issued.
- ctrl_busy rising during WAIT_ACK: no effect.
- Reset mid-transaction: immediate return to reset state. The in-flight command is abandoned; the controller shares the reset.

Optional Feature:
- Macro: SDRAM_BRIDGE_RD_CACHE_EN.
- With the macro: a one-entry read cache {valid, tag[SOC_ADDR_WIDTH], data[32]}.
  - Read hit in IDLE (valid && tag == word addr): go straight to DONE with the cached data, regardless of ctrl_busy; no controller command.
  - Read miss: normal path; on ctrl_ready, fill the entry.
  - Write to the tagged address: on write completion, merge wdata bytes per wstrb into the entry (write-through).
  - Timeout or reset: invalidate the entry.
- Without the macro: every read reaches the controller, and there is no cache storage.

Decomposition:
- Package sdram_bridge_pkg holds:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT_ACK=2'd2, DONE=2'd3);
  - TIMEOUT_RDATA=32'hDEAD_BEEF;
  - the strobe-to-mask function.
- Sub-module sdram_bridge_rd_cache (tag compare, fill, byte-merge) is instantiated only under SDRAM_BRIDGE_RD_CACHE_EN.

Test Plan:
- Write at mem_addr=0x0000_0010, wdata=0xCAFEBABE, wstrb=4'hF, with the controller model acking 5 cycles after wr_en → ctrl_addr=23'h4, ctrl_wr_mask=4'h0, ctrl_wr_en high exactly 1 cycle, mem_ready 1 cycle after ctrl_ready.
- Partial write with wstrb=4'b0101 → ctrl_wr_mask=4'b1010; the subsequent read of the same address returns model data 0x11223344 on mem_rdata with mem_ready.
- ctrl_busy held high for 200 cycles after reset while mem_valid=1 → no wr_en/rd_en until busy falls; command issued 1 cycle after busy low; timeout_err stays 0.
- Model never asserts ctrl_ready on a read → after TIMEOUT_CYCLES cycles mem_ready pulses with mem_rdata=0xDEADBEEF, timeout_err=1 and still 1 after the next good transaction.
- reset_n_port dropped during WAIT_ACK → outputs return to reset values asynchronously; a stray ctrl_ready afterwards does not produce mem_ready.
- With SDRAM_BRIDGE_RD_CACHE_EN: two reads of 0x100 → one rd_en; the second mem_ready arrives 2 cycles after valid with busy=1; a write of 0x000000FF, wstrb=4'b0001 to 0x100 followed by a read returns the merged byte without rd_en.
